// File: rtl/gamecube_pkg.sv
// Shared constants, cell timing multipliers and FSM state encoding for the
// GameCube controller-side responder.
package gamecube_pkg;

   localparam logic [7:0]  CMD_IDENTIFY = 8'h00;
   localparam logic [7:0]  CMD_POLL     = 8'h40;
   localparam logic [23:0] ID_WORD      = 24'h090003;

   localparam int US_1 = 1;
   localparam int US_2 = 2;
   localparam int US_3 = 3;
   localparam int US_4 = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RX_LOW,
      S_RX_HIGH,
      S_WAIT_REPLY,
      S_TX_BIT,
      S_TX_STOP,
      S_ERR_WAIT
   } gc_state_t;

   // Timing counters must span two full bit cells.
   function automatic int cnt_width(input int clks_per_us);
      return $clog2(US_4 * clks_per_us * 2);
   endfunction

endpackage

// File: rtl/gamecube_device_bit_encoder.sv
// Reply cell generator: holds the line low for 1 us (bit 1) or 3 us (bit 0)
// inside a 4 us cell, or 2 us low in a 2 us cell when stop is set.
module gamecube_device_bit_encoder
   import gamecube_pkg::*;
#(
   parameter int CLKS_PER_US = 50,
   parameter int CW          = 9
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic bit_val,
   input  logic stop,
   output logic drive_low,
   output logic done
);

   localparam logic [CW-1:0] T1  = CW'(US_1 * CLKS_PER_US);
   localparam logic [CW-1:0] T2  = CW'(US_2 * CLKS_PER_US);
   localparam logic [CW-1:0] T3  = CW'(US_3 * CLKS_PER_US);
   localparam logic [CW-1:0] T4  = CW'(US_4 * CLKS_PER_US);
   localparam logic [CW-1:0] ONE = CW'(1);

   logic          active;
   logic [CW-1:0] cell_left;
   logic [CW-1:0] low_left;

   // A start in the done cycle reloads immediately, so cells abut with no gap.
   always_ff @(posedge clk) begin
      if (rst) begin
         active    <= 1'b0;
         cell_left <= '0;
         low_left  <= '0;
      end else if (start) begin
         active    <= 1'b1;
         cell_left <= stop ? T2 : T4;
         low_left  <= stop ? T2 : (bit_val ? T1 : T3);
      end else if (active) begin
         if (cell_left == ONE) active <= 1'b0;
         if (cell_left != '0) cell_left <= cell_left - ONE;
         if (low_left != '0) low_left <= low_left - ONE;
      end
   end

   assign drive_low = active && (low_left != '0);
   assign done      = active && (cell_left == ONE);

endmodule

// File: rtl/gamecube_controller_responder.sv
// Controller-side GameCube single-wire responder: decodes IDENTIFY/POLL
// frames from the host and answers with the ID word or the STATUS word.
//
// state        | meaning
// S_IDLE       | line idle, waiting for the first falling edge of a frame
// S_RX_LOW     | inside a host cell, waiting for the 2 us sample point
// S_RX_HIGH    | bit taken, waiting for the next cell's falling edge
// S_WAIT_REPLY | stop bit seen, line must stay high before replying
// S_TX_BIT     | driving reply data cells MSB first
// S_TX_STOP    | driving the 2 us reply stop bit
// S_ERR_WAIT   | frame rejected, waiting for the line to go idle
module gamecube_controller_responder
   import gamecube_pkg::*;
#(
   parameter int CLKS_PER_US     = 50,
   parameter int REPLY_DELAY_US  = 4,
   parameter int IDLE_TIMEOUT_US = 6
) (
   input  logic        CLK,
   input  logic        RST,
   inout  wire         DATALINE,
   input  logic [63:0] STATUS,
   output logic        RUMBLE,
   output logic        POLL_STROBE,
   output logic        CMD_ERROR,
   output logic        BUSY
);

   localparam int CW = cnt_width(CLKS_PER_US);
   localparam logic [CW-1:0] T_SAMPLE    = CW'(US_2 * CLKS_PER_US);
   localparam logic [CW-1:0] T_MALFORMED = CW'(US_4 * CLKS_PER_US);
   localparam logic [CW-1:0] T_REPLY     = CW'(REPLY_DELAY_US * CLKS_PER_US);
   localparam logic [CW-1:0] T_IDLE      = CW'(IDLE_TIMEOUT_US * CLKS_PER_US);
   localparam logic [CW-1:0] ONE         = CW'(1);

   gc_state_t     state;
   logic          sync_1, sync_2, line_d;
   logic [CW-1:0] elapsed, high_cnt;
   logic [4:0]    bit_cnt, frame_len;
   logic [23:0]   rx_sh;
   logic [23:0]   rx_next;
   logic          is_poll;
   logic [63:0]   tx_sh;
   logic [6:0]    tx_left;
   logic          tx_first;
   logic          fall;
   logic          enc_start, enc_stop, enc_done, drive_low;

   assign fall      = line_d & ~sync_2;
   assign rx_next   = {rx_sh[22:0], sync_2};
   assign enc_start = (state == S_TX_BIT) && (tx_first || enc_done);
   assign enc_stop  = (tx_left == 7'd0);
   assign DATALINE  = drive_low ? 1'b0 : 1'bz;

   // Synchronisers reset high so reset release never looks like a falling edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_1   <= 1'b1;
         sync_2   <= 1'b1;
         line_d   <= 1'b1;
         high_cnt <= '0;
      end else begin
         sync_1 <= DATALINE;
         sync_2 <= sync_1;
         line_d <= sync_2;
         if (!sync_2) high_cnt <= '0;
         else if (high_cnt != '1) high_cnt <= high_cnt + ONE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= S_IDLE;
         elapsed     <= '0;
         bit_cnt     <= '0;
         frame_len   <= '0;
         rx_sh       <= '0;
         is_poll     <= 1'b0;
         tx_sh       <= '0;
         tx_left     <= '0;
         tx_first    <= 1'b0;
         RUMBLE      <= 1'b0;
         POLL_STROBE <= 1'b0;
         CMD_ERROR   <= 1'b0;
         BUSY        <= 1'b0;
      end else begin
         POLL_STROBE <= 1'b0;
         CMD_ERROR   <= 1'b0;
         if (elapsed != '1) elapsed <= elapsed + ONE;
         case (state)
            S_IDLE: if (fall) begin
               state     <= S_RX_LOW;
               BUSY      <= 1'b1;
               bit_cnt   <= '0;
               frame_len <= 5'd8;
               is_poll   <= 1'b0;
               elapsed   <= '0;
            end
            S_RX_LOW: if (elapsed == T_SAMPLE) begin
               if (bit_cnt == frame_len) begin
                  if (sync_2) state <= S_WAIT_REPLY;
                  else begin
                     state     <= S_ERR_WAIT;
                     CMD_ERROR <= 1'b1;
                  end
               end else begin
                  rx_sh   <= rx_next;
                  bit_cnt <= bit_cnt + 5'd1;
                  state   <= S_RX_HIGH;
                  if (bit_cnt == 5'd7) begin
                     if (rx_next[7:0] == CMD_POLL) begin
                        frame_len <= 5'd24;
                        is_poll   <= 1'b1;
                     end else if (rx_next[7:0] != CMD_IDENTIFY) begin
                        state     <= S_ERR_WAIT;
                        CMD_ERROR <= 1'b1;
                     end
                  end
               end
            end
            S_RX_HIGH: begin
               if (fall) begin
                  state   <= S_RX_LOW;
                  elapsed <= '0;
               end else if ((!sync_2 && elapsed >= T_MALFORMED) ||
                            (sync_2 && high_cnt >= T_IDLE)) begin
                  state     <= S_ERR_WAIT;
                  CMD_ERROR <= 1'b1;
               end
            end
            S_WAIT_REPLY: begin
               if (fall) begin
                  state     <= S_ERR_WAIT;
                  CMD_ERROR <= 1'b1;
               end else if (high_cnt >= T_REPLY) begin
                  state    <= S_TX_BIT;
                  tx_first <= 1'b1;
                  if (is_poll) begin
                     tx_sh       <= STATUS;
                     tx_left     <= 7'd64;
                     RUMBLE      <= rx_sh[0];
                     POLL_STROBE <= 1'b1;
                  end else begin
                     tx_sh   <= {ID_WORD, 40'h0};
                     tx_left <= 7'd24;
                  end
               end
            end
            S_TX_BIT: begin
               // With no data left, the start issued on done launches the stop cell.
               if (enc_start && tx_left != 7'd0) begin
                  tx_first <= 1'b0;
                  tx_sh    <= {tx_sh[62:0], 1'b0};
                  tx_left  <= tx_left - 7'd1;
               end
               if (enc_done && tx_left == 7'd0) state <= S_TX_STOP;
            end
            S_TX_STOP: if (enc_done) begin
               state <= S_IDLE;
               BUSY  <= 1'b0;
            end
            S_ERR_WAIT: if (sync_2 && high_cnt >= T_IDLE) begin
               state <= S_IDLE;
               BUSY  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   gamecube_device_bit_encoder #(
      .CLKS_PER_US (CLKS_PER_US),
      .CW          (CW)
   ) u_enc (
      .clk       (CLK),
      .rst       (RST),
      .start     (enc_start),
      .bit_val   (tx_sh[63]),
      .stop      (enc_stop),
      .drive_low (drive_low),
      .done      (enc_done)
   );

endmodule

// File: tb/tb_gamecube_controller_responder.sv
// Scoreboard bench: host frames push expected replies/pulses, a line monitor
// decodes device activity and compares against the queue.
module tb_gamecube_controller_responder;

   localparam int CPU = 8;
   localparam int K_REPLY  = 0;
   localparam int K_ERR    = 1;
   localparam int K_STROBE = 2;

   typedef struct {
      int          kind;
      int          nbits;
      logic [63:0] data;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        host_low;
   logic [63:0] status;
   logic        rumble, poll_strobe, cmd_error, busy;
   wire         dataline;

   int          total = 0;
   int          bad   = 0;
   ev_t         exp_q[$];
   int          pw    = 0;
   int          mbits = 0;
   logic [63:0] mdata = '0;
   logic        dev_low;

   always #5 clk = ~clk;

   pullup (dataline);
   assign dataline = host_low ? 1'b0 : 1'bz;
   assign dev_low  = (dataline === 1'b0) && !host_low;

   gamecube_controller_responder #(
      .CLKS_PER_US     (CPU),
      .REPLY_DELAY_US  (4),
      .IDLE_TIMEOUT_US (6)
   ) dut (
      .CLK         (clk),
      .RST         (rst),
      .DATALINE    (dataline),
      .STATUS      (status),
      .RUMBLE      (rumble),
      .POLL_STROBE (poll_strobe),
      .CMD_ERROR   (cmd_error),
      .BUSY        (busy)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic expect_ev(input int kind, input int nbits, input logic [63:0] data);
      ev_t e;
      e.kind  = kind;
      e.nbits = nbits;
      e.data  = data;
      exp_q.push_back(e);
   endtask

   task automatic post_event(input int kind, input int nbits, input logic [63:0] data);
      ev_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_event: got kind=%0d nbits=%0d data=%0h, want no event",
                  kind, nbits, data);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", 64'(kind), 64'(e.kind));
         check("event_nbits", 64'(nbits), 64'(e.nbits));
         check("event_data", data, e.data);
      end
   endtask

   // Device cells: 1 us low = 1, 3 us low = 0, 2 us low = stop.
   always @(negedge clk) begin
      if (rst) begin
         pw    = 0;
         mbits = 0;
         mdata = '0;
      end else begin
         if (dev_low) pw++;
         else if (pw != 0) begin
            if (pw <= (3 * CPU) / 2) begin
               mdata = {mdata[62:0], 1'b1};
               mbits++;
            end else if (pw <= (5 * CPU) / 2) begin
               post_event(K_REPLY, mbits, mdata);
               mbits = 0;
               mdata = '0;
            end else begin
               mdata = {mdata[62:0], 1'b0};
               mbits++;
            end
            pw = 0;
         end
         if (cmd_error) post_event(K_ERR, 0, 64'h0);
         if (poll_strobe) post_event(K_STROBE, 0, {63'h0, rumble});
      end
   end

   task automatic host_bit(input logic b);
      host_low = 1'b1;
      repeat (b ? CPU : 3 * CPU) @(negedge clk);
      host_low = 1'b0;
      repeat (b ? 3 * CPU : CPU) @(negedge clk);
   endtask

   task automatic host_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) host_bit(v[i]);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle"}, 64'(busy), 64'h0);
   endtask

   initial begin
      int n;
      rst      = 1'b1;
      host_low = 1'b0;
      status   = '0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_busy", 64'(busy), 64'h0);
      check("reset_rumble", 64'(rumble), 64'h0);
      check("reset_strobe", 64'(poll_strobe), 64'h0);
      check("reset_error", 64'(cmd_error), 64'h0);
      check("reset_line", 64'(dataline), 64'h1);

      // IDENTIFY
      expect_ev(K_REPLY, 24, 64'h090003);
      host_byte(8'h00);
      check("busy_in_frame", 64'(busy), 64'h1);
      host_bit(1'b1);
      wait_idle("identify");
      repeat (20) @(negedge clk);

      // POLL with rumble on; STATUS changes mid-reply
      status = 64'h0080_8080_8080_0000;
      expect_ev(K_STROBE, 0, 64'h1);
      expect_ev(K_REPLY, 64, 64'h0080_8080_8080_0000);
      host_byte(8'h40);
      host_byte(8'h03);
      host_byte(8'h01);
      host_bit(1'b1);
      repeat (200) @(negedge clk);
      status = 64'hFFFF_0000_FFFF_0000;
      wait_idle("poll");
      check("rumble_after_poll", 64'(rumble), 64'h1);
      repeat (20) @(negedge clk);

      // Unknown opcode
      expect_ev(K_ERR, 0, 64'h0);
      host_byte(8'h55);
      repeat (15) @(negedge clk);
      check("busy_during_err_wait", 64'(busy), 64'h1);
      wait_idle("bad_opcode");
      repeat (20) @(negedge clk);

      // Host stalls after 10 bits of a POLL, then a clean IDENTIFY
      expect_ev(K_ERR, 0, 64'h0);
      host_byte(8'h40);
      host_bit(1'b0);
      host_bit(1'b0);
      wait_idle("stall");
      check("rumble_held", 64'(rumble), 64'h1);
      repeat (10) @(negedge clk);
      expect_ev(K_REPLY, 24, 64'h090003);
      host_byte(8'h00);
      host_bit(1'b1);
      wait_idle("identify_after_stall");
      repeat (20) @(negedge clk);

      // Malformed cell: low for 40 cycles
      expect_ev(K_ERR, 0, 64'h0);
      host_low = 1'b1;
      repeat (40) @(negedge clk);
      host_low = 1'b0;
      wait_idle("malformed");
      repeat (20) @(negedge clk);

      // Stop bit sampled as 0
      expect_ev(K_ERR, 0, 64'h0);
      host_byte(8'h00);
      host_bit(1'b0);
      wait_idle("bad_stop");
      repeat (20) @(negedge clk);

      // Reset during the 30th reply bit
      status = 64'h1234_5678_9ABC_DEF0;
      expect_ev(K_STROBE, 0, 64'h1);
      host_byte(8'h40);
      host_byte(8'h03);
      host_byte(8'h01);
      host_bit(1'b1);
      n = 0;
      while (!(mbits == 29 && dev_low) && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("reached_bit30", 64'(mbits), 64'd29);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_line_released", 64'(dataline), 64'h1);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_rumble", 64'(rumble), 64'h0);
      check("rst_strobe", 64'(poll_strobe), 64'h0);
      check("rst_error", 64'(cmd_error), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // POLL after reset, rumble off
      status = 64'hA5A5_0F0F_3C3C_0001;
      expect_ev(K_STROBE, 0, 64'h0);
      expect_ev(K_REPLY, 64, 64'hA5A5_0F0F_3C3C_0001);
      host_byte(8'h40);
      host_byte(8'h03);
      host_byte(8'h00);
      host_bit(1'b1);
      wait_idle("poll_after_reset");
      repeat (20) @(negedge clk);

      check("queue_drained", 64'(exp_q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
